// File: rtl/lc3_decode_if.sv
// Fetch/controller-to-decode-to-execute bundle for the LC-3 decode stage.
// With LC3_DECODE_ILLEGAL_CHECK_EN defined, the bundle also carries illegal_op.
interface lc3_decode_if #(
  parameter int DATA_W = 16
);
  logic              enable_decode;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] npc_in;

  logic [DATA_W-1:0] IR;
  logic [DATA_W-1:0] npc_out;
  logic [5:0]        E_Control;
  logic [1:0]        W_Control;
  logic              Mem_Control;
  logic              decode_valid;
`ifdef LC3_DECODE_ILLEGAL_CHECK_EN
  logic              illegal_op;

  modport master (
    output enable_decode, dout, npc_in,
    input  IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op
  );
  modport slave (
    input  enable_decode, dout, npc_in,
    output IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op
  );
`else
  modport master (
    output enable_decode, dout, npc_in,
    input  IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid
  );
  modport slave (
    input  enable_decode, dout, npc_in,
    output IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid
  );
`endif
endinterface

// File: rtl/lc3_decode.sv
// LC-3 decode stage: registers IR/next-PC and the execute/writeback/memory control bundles.
// Optional illegal-opcode flag built only when LC3_DECODE_ILLEGAL_CHECK_EN is defined.
module lc3_decode #(
  parameter int DATA_W = 16
) (
  input logic         clock,
  input logic         reset,
  lc3_decode_if.slave bus
);
  localparam int OPC_LSB = DATA_W - 4;

  typedef enum logic [3:0] {
    OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
    OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7,
    OP_RTI = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB,
    OP_JMP = 4'hC, OP_RES = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
  } opcode_t;

  typedef struct packed {
    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
  } e_ctrl_t;

  opcode_t opcode;
  e_ctrl_t e_next;
  logic [1:0] w_next;
  logic       m_next;

  assign opcode = opcode_t'(bus.dout[DATA_W-1:OPC_LSB]);

  // NOTE: every field gets a default before the case so no path leaves a value
  // unassigned; otherwise synthesis infers latches on the decode signals.
  always_comb begin
    e_next = '0;
    w_next = 2'b00;
    m_next = 1'b0;
    case (opcode)
      OP_ADD: e_next.op2select = ~bus.dout[5];
      OP_AND: begin
        e_next.alu_control = 2'b01;
        e_next.op2select   = ~bus.dout[5];
      end
      OP_NOT: e_next.alu_control = 2'b10;
      OP_BR, OP_ST: begin
        e_next.pcselect1 = 2'b01;
        e_next.pcselect2 = 1'b1;
      end
      OP_LD: begin
        e_next.pcselect1 = 2'b01;
        e_next.pcselect2 = 1'b1;
        w_next           = 2'b01;
      end
      OP_LDI: begin
        e_next.pcselect1 = 2'b01;
        e_next.pcselect2 = 1'b1;
        w_next           = 2'b01;
        m_next           = 1'b1;
      end
      OP_STI: begin
        e_next.pcselect1 = 2'b01;
        e_next.pcselect2 = 1'b1;
        m_next           = 1'b1;
      end
      OP_LEA: begin
        e_next.pcselect1 = 2'b01;
        e_next.pcselect2 = 1'b1;
        w_next           = 2'b10;
      end
      OP_LDR: begin
        e_next.pcselect1 = 2'b10;
        w_next           = 2'b01;
      end
      OP_STR: e_next.pcselect1 = 2'b10;
      OP_JMP: e_next.pcselect1 = 2'b11;
      default: ;  // JSR, RTI, reserved, TRAP: no control activity
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.IR           <= '0;
      bus.npc_out      <= '0;
      bus.E_Control    <= '0;
      bus.W_Control    <= '0;
      bus.Mem_Control  <= 1'b0;
      bus.decode_valid <= 1'b0;
    end else if (bus.enable_decode) begin
      bus.IR           <= bus.dout;
      bus.npc_out      <= bus.npc_in;
      bus.E_Control    <= e_next;
      bus.W_Control    <= w_next;
      bus.Mem_Control  <= m_next;
      bus.decode_valid <= 1'b1;
    end else begin
      bus.decode_valid <= 1'b0;
    end
  end

`ifdef LC3_DECODE_ILLEGAL_CHECK_EN
  logic illegal_next;

  assign illegal_next = (opcode == OP_JSR) || (opcode == OP_RTI) ||
                        (opcode == OP_RES) || (opcode == OP_TRAP);

  always_ff @(posedge clock) begin
    if (reset)                  bus.illegal_op <= 1'b0;
    else if (bus.enable_decode) bus.illegal_op <= illegal_next;
  end
`endif
endmodule

// File: tb/tb_lc3_decode.sv
// Self-checking bench for lc3_decode: opcode-table reference model compared every cycle,
// plus literal checks of the documented decode cases and random stimulus.
module tb_lc3_decode;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  lc3_decode_if #(.DATA_W(16)) bus ();

  lc3_decode #(.DATA_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference tables indexed by opcode: E_Control without the op2 bit, W_Control, Mem_Control.
  logic [5:0] tab_e [16];
  logic [1:0] tab_w [16];
  logic       tab_m [16];
  logic       tab_ill [16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      tab_e[i] = 6'b0; tab_w[i] = 2'b0; tab_m[i] = 1'b0; tab_ill[i] = 1'b0;
    end
    tab_e[4'h0] = 6'b000110;                                      // BR
    tab_e[4'h2] = 6'b000110; tab_w[4'h2] = 2'b01;                 // LD
    tab_e[4'h3] = 6'b000110;                                      // ST
    tab_e[4'h5] = 6'b010000;                                      // AND
    tab_e[4'h6] = 6'b001000; tab_w[4'h6] = 2'b01;                 // LDR
    tab_e[4'h7] = 6'b001000;                                      // STR
    tab_e[4'h9] = 6'b100000;                                      // NOT
    tab_e[4'hA] = 6'b000110; tab_w[4'hA] = 2'b01; tab_m[4'hA] = 1'b1;  // LDI
    tab_e[4'hB] = 6'b000110; tab_m[4'hB] = 1'b1;                  // STI
    tab_e[4'hC] = 6'b001100;                                      // JMP
    tab_e[4'hE] = 6'b000110; tab_w[4'hE] = 2'b10;                 // LEA
    tab_ill[4'h4] = 1'b1; tab_ill[4'h8] = 1'b1; tab_ill[4'hD] = 1'b1; tab_ill[4'hF] = 1'b1;
  end

  // Model state, advanced on each rising edge from the inputs the DUT sees.
  logic [15:0] m_ir, m_npc;
  logic [5:0]  m_e;
  logic [1:0]  m_w;
  logic        m_m, m_v, m_ill;
  logic        started = 1'b0;
  logic        done    = 1'b0;

  always @(posedge clock) begin
    started <= 1'b1;
    if (reset) begin
      m_ir <= '0; m_npc <= '0; m_e <= '0; m_w <= '0; m_m <= 1'b0; m_v <= 1'b0; m_ill <= 1'b0;
    end else if (bus.enable_decode) begin
      m_ir  <= bus.dout;
      m_npc <= bus.npc_in;
      m_e   <= tab_e[bus.dout[15:12]] |
               {5'b0, ((bus.dout[15:12] == 4'h1) || (bus.dout[15:12] == 4'h5)) && !bus.dout[5]};
      m_w   <= tab_w[bus.dout[15:12]];
      m_m   <= tab_m[bus.dout[15:12]];
      m_v   <= 1'b1;
      m_ill <= tab_ill[bus.dout[15:12]];
    end else begin
      m_v <= 1'b0;
    end
  end

  always @(negedge clock) begin
    if (started && !done) begin
      check("ir",    bus.IR,                    m_ir);
      check("npc",   bus.npc_out,               m_npc);
      check("e_ctl", {10'b0, bus.E_Control},    {10'b0, m_e});
      check("w_ctl", {14'b0, bus.W_Control},    {14'b0, m_w});
      check("m_ctl", {15'b0, bus.Mem_Control},  {15'b0, m_m});
      check("valid", {15'b0, bus.decode_valid}, {15'b0, m_v});
`ifdef LC3_DECODE_ILLEGAL_CHECK_EN
      check("illegal", {15'b0, bus.illegal_op}, {15'b0, m_ill});
`endif
    end
  end

  task automatic step(input logic r, input logic en, input logic [15:0] d, input logic [15:0] n);
    reset             = r;
    bus.enable_decode = en;
    bus.dout          = d;
    bus.npc_in        = n;
    @(posedge clock);
    #2;
  endtask

  task automatic check_all(input string name, input logic [15:0] ir, input logic [15:0] npc,
                           input logic [5:0] e, input logic [1:0] w, input logic m, input logic v);
    check({name, "_ir"},    bus.IR,                    ir);
    check({name, "_npc"},   bus.npc_out,               npc);
    check({name, "_e"},     {10'b0, bus.E_Control},    {10'b0, e});
    check({name, "_w"},     {14'b0, bus.W_Control},    {14'b0, w});
    check({name, "_m"},     {15'b0, bus.Mem_Control},  {15'b0, m});
    check({name, "_valid"}, {15'b0, bus.decode_valid}, {15'b0, v});
  endtask

  initial begin
    // Reset held with a capture pending: reset must win.
    step(1'b1, 1'b1, 16'h1042, 16'h3001);
    step(1'b1, 1'b1, 16'h1042, 16'h3001);
    check_all("reset", 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0, 1'b0);
`ifdef LC3_DECODE_ILLEGAL_CHECK_EN
    check("reset_illegal", {15'b0, bus.illegal_op}, 16'h0);
`endif

    step(1'b0, 1'b1, 16'h1042, 16'h3001);
    check_all("add_reg", 16'h1042, 16'h3001, 6'b000001, 2'b00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h1062, 16'h3002);
    check_all("add_imm", 16'h1062, 16'h3002, 6'b000000, 2'b00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'hA405, 16'h3003);
    check_all("ldi", 16'hA405, 16'h3003, 6'b000110, 2'b01, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h6283, 16'h3004);
    check_all("ldr", 16'h6283, 16'h3004, 6'b001000, 2'b01, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'hC1C0, 16'h3005);
    check_all("jmp", 16'hC1C0, 16'h3005, 6'b001100, 2'b00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h927F, 16'h3006);
    check_all("not", 16'h927F, 16'h3006, 6'b100000, 2'b00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'hE00F, 16'h3007);
    check_all("lea", 16'hE00F, 16'h3007, 6'b000110, 2'b10, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'hF025, 16'h3008);
    check_all("trap", 16'hF025, 16'h3008, 6'b000000, 2'b00, 1'b0, 1'b1);

    // Hold: last AND decode stays stable while dout moves.
    step(1'b0, 1'b1, 16'h5042, 16'h3009);
    check_all("and", 16'h5042, 16'h3009, 6'b010001, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'hE00F, 16'h4000);
      check_all("hold", 16'h5042, 16'h3009, 6'b010001, 2'b00, 1'b0, 1'b0);
    end

`ifdef LC3_DECODE_ILLEGAL_CHECK_EN
    step(1'b0, 1'b1, 16'hD000, 16'h3010);
    check("ill_set", {15'b0, bus.illegal_op}, 16'h1);
    step(1'b0, 1'b0, 16'h1042, 16'h3011);
    check("ill_hold", {15'b0, bus.illegal_op}, 16'h1);
    step(1'b0, 1'b1, 16'h1042, 16'h3011);
    check("ill_clr", {15'b0, bus.illegal_op}, 16'h0);
    step(1'b0, 1'b1, 16'h8000, 16'h3012);
    step(1'b1, 1'b1, 16'hD000, 16'h3013);
    check("ill_reset", {15'b0, bus.illegal_op}, 16'h0);
`endif

    // Random traffic: mostly enabled, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70),
           16'($urandom), 16'($urandom));
    end

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
